axi_read_arbiter: RTL
=====================

Name: axi_read_arbiter

Overview:
- Shares one AXI read port (AR + R channels) between two cache masters: master 0 = ICache refill, master 1 = DCache miss handler.
- Sits between the cache AXI bundles and the SoC memory port.
- Arbitrates AR with round-robin, tags the outgoing ID with the master index, and routes R beats back by that tag.
- Tracks outstanding bursts per master so a busy master cannot overrun the slave's ID space.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 64, R data width.
- ID_WIDTH, 4, master-side ID width; the slave-side ID is ID_WIDTH+1.
- MAX_OUTSTANDING, 4, maximum in-flight bursts per master (power of two not required, ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_arvalid  in  2  per-master AR valid
- m_arready  out  2  per-master AR ready
- m_araddr  in  2*ADDR_WIDTH  per-master address (master k at slice k)
- m_arid  in  2*ID_WIDTH  per-master ID
- m_arlen  in  2*8  burst length
- m_arsize  in  2*3  burst size
- m_arburst  in  2*2  burst type
- m_rvalid  out  2  per-master R valid
- m_rready  in  2  per-master R ready
- m_rdata  out  DATA_WIDTH  R data, broadcast to both masters
- m_rid  out  ID_WIDTH  s_rid with the tag bit stripped, broadcast
- m_rresp  out  2  broadcast
- m_rlast  out  1  broadcast
- s_arvalid/s_arready  out/in  1  slave AR handshake
- s_araddr, s_arlen, s_arsize, s_arburst  out  ADDR_WIDTH/8/3/2  muxed from the granted master
- s_arid  out  ID_WIDTH+1  {grant_idx, m_arid[grant]}
- s_rvalid/s_rready  in/out  1  slave R handshake
- s_rdata, s_rid, s_rresp, s_rlast  in  DATA_WIDTH/ID_WIDTH+1/2/1  slave R beat
- idle  out  1  high when both outstanding counters are 0 and no AR is locked

Behaviour:
- Reset state:
  - counters cnt[0..1]=0, lock=0, rr_ptr=0 (master 0 favoured first).
  - While rst=1, all valid/ready outputs are forced to 0; idle=1 after reset.
- Eligibility:
  - elig[k] = m_arvalid[k] && cnt[k] != MAX_OUTSTANDING.
- AR FSM, two states:
  - IDLE:
    - If both masters are eligible, grant rr_ptr; otherwise grant the single eligible master; with none eligible, s_arvalid=0.
    - The grant is combinational, so a request appearing in a cycle can handshake in that same cycle (zero-cycle latency).
    - If s_arvalid && !s_arready, go to LOCK and register the granted index.
  - LOCK:
    - Grant is fixed to the registered index regardless of the other master. This keeps s_ar* stable, as AXI requires.
    - Return to IDLE on s_arready.
  - Handshake, in either state:
    - m_arready[g] = s_arready; the other master sees 0.
    - On the handshake, cnt[g]++ and rr_ptr = ~g.
- R routing:
  - sel = s_rid[ID_WIDTH]; m_rvalid[k] = s_rvalid && sel==k; s_rready = m_rready[sel].
  - Purely combinational; no buffering, zero latency.
- Counter decrement:
  - On s_rvalid && s_rready && s_rlast, cnt[sel]--.
  - If AR increment and R-last decrement hit the same master in one cycle, cnt is unchanged.
  - A decrement at cnt=0 (protocol violation) saturates at 0; the beat is still routed.
- Counter width is $clog2(MAX_OUTSTANDING+1). At cnt=MAX_OUTSTANDING the master is not granted, but any burst already LOCKed completes.
- Ordering:
  - No reordering is performed; per-ID ordering is the slave's responsibility.
  - Interleaved R beats of the two masters are legal and routed beat-by-beat.
- Reset mid-burst: all state clears; the slave is expected to be reset together with this block.

Optional Feature:
- Macro AXI_ARB_ICACHE_PRIO_EN.
- When defined: fixed priority in IDLE. Master 0 (ICache) wins whenever eligible; rr_ptr is unused.
- LOCK behaviour and counters are unchanged.
- When undefined: round-robin as above.

Test Plan:
- Single request, slave ready: after reset, m_arvalid=01, m_arid[0]=3, s_arready=1 → same cycle s_arvalid=1, s_arid=5'b0_0011, m_arready=01; next cycle cnt[0]=1, idle=0.
- Contention with backpressure: both valid, s_arready=0 for 3 cycles → master 0 held on s_ar* for all 3 cycles (LOCK). On ready, next grant goes to master 1 with s_arid[4]=1.
- Full counter: MAX_OUTSTANDING=4; issue 4 master-1 bursts with no R traffic → 5th master-1 request gets m_arready[1]=0 while master 0 is still granted. One rlast for tag 1 → master 1 is granted the next cycle.
- R routing and stripping: s_rvalid=1, s_rid=5'b1_0110, s_rlast=1, m_rready=10 → m_rvalid=10, m_rid=4'b0110, s_rready=1, cnt[1] decrements.
- Simultaneous inc/dec: master 0 AR handshake and master 0 rlast in the same cycle with cnt[0]=2 → cnt[0] stays 2.
- Feature test with AXI_ARB_ICACHE_PRIO_EN: both valid continuously, s_arready=1 → master 0 granted every cycle until its counter reaches 4; master 1 granted only then.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read-port arbiter: round-robin AR grant, ID tagging and R routing by tag.
// Define AXI_ARB_ICACHE_PRIO_EN to give master 0 (ICache) fixed priority instead of round-robin.
module axi_read_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              m_arvalid,
    output logic [1:0]              m_arready,
    input  logic [2*ADDR_WIDTH-1:0] m_araddr,
    input  logic [2*ID_WIDTH-1:0]   m_arid,
    input  logic [15:0]             m_arlen,
    input  logic [5:0]              m_arsize,
    input  logic [3:0]              m_arburst,
    output logic [1:0]              m_rvalid,
    input  logic [1:0]              m_rready,
    output logic [DATA_WIDTH-1:0]   m_rdata,
    output logic [ID_WIDTH-1:0]     m_rid,
    output logic [1:0]              m_rresp,
    output logic                    m_rlast,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic [7:0]              s_arlen,
    output logic [2:0]              s_arsize,
    output logic [1:0]              s_arburst,
    output logic [ID_WIDTH:0]       s_arid,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [ID_WIDTH:0]       s_rid,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rlast,
    output logic                    idle
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTSTANDING);

    typedef enum logic {ST_IDLE, ST_LOCK} state_e;

    state_e        state_q, state_d;
    logic          lockIdx_q, lockIdx_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
`ifndef AXI_ARB_ICACHE_PRIO_EN
    logic          rrPtr_q, rrPtr_d;
`endif

    logic [1:0] elig;
    logic       grant;
    logic       arValid;
    logic       arHs;
    logic       rSel;
    logic       rLastHs;

    assign elig[0] = m_arvalid[0] && (cnt_q[0] != MaxCnt);
    assign elig[1] = m_arvalid[1] && (cnt_q[1] != MaxCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lockIdx_q <= 1'b0;
            cnt_q     <= '{default: '0};
`ifndef AXI_ARB_ICACHE_PRIO_EN
            rrPtr_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lockIdx_q <= lockIdx_d;
            cnt_q     <= cnt_d;
`ifndef AXI_ARB_ICACHE_PRIO_EN
            rrPtr_q   <= rrPtr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        lockIdx_d = lockIdx_q;
        case (state_q)
            ST_IDLE: begin
                if (arValid && !s_arready) begin
                    state_d   = ST_LOCK;
                    lockIdx_d = grant;
                end
            end
            ST_LOCK: begin
                if (s_arready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A stalled request keeps its grant so the slave sees stable s_ar* until accepted.
    always_comb begin
        grant   = 1'b0;
        arValid = 1'b0;
        if (state_q == ST_LOCK) begin
            grant   = lockIdx_q;
            arValid = m_arvalid[lockIdx_q];
        end else begin
            arValid = |elig;
            if (&elig) begin
`ifdef AXI_ARB_ICACHE_PRIO_EN
                grant = 1'b0;
`else
                grant = rrPtr_q;
`endif
            end else begin
                grant = elig[1];
            end
        end
    end

    assign s_arvalid = arValid && !rst;
    assign arHs      = s_arvalid && s_arready;
    assign m_arready = arHs ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign s_araddr  = grant ? m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_araddr[ADDR_WIDTH-1:0];
    assign s_arlen   = grant ? m_arlen[15:8] : m_arlen[7:0];
    assign s_arsize  = grant ? m_arsize[5:3] : m_arsize[2:0];
    assign s_arburst = grant ? m_arburst[3:2] : m_arburst[1:0];
    assign s_arid    = {grant, (grant ? m_arid[2*ID_WIDTH-1:ID_WIDTH] : m_arid[ID_WIDTH-1:0])};

    assign rSel     = s_rid[ID_WIDTH];
    assign m_rvalid = {s_rvalid && rSel && !rst, s_rvalid && !rSel && !rst};
    assign s_rready = m_rready[rSel] && !rst;
    assign rLastHs  = s_rvalid && s_rready && s_rlast;
    assign m_rdata  = s_rdata;
    assign m_rid    = s_rid[ID_WIDTH-1:0];
    assign m_rresp  = s_rresp;
    assign m_rlast  = s_rlast;

    // Same-cycle issue and completion on one master cancel; a stray completion at zero is ignored.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = cnt_q[k];
            if (arHs && (grant == 1'(k)) && !(rLastHs && (rSel == 1'(k)))) begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end else if (rLastHs && (rSel == 1'(k)) && !(arHs && (grant == 1'(k)))
                         && (cnt_q[k] != '0)) begin
                cnt_d[k] = cnt_q[k] - CW'(1);
            end
        end
`ifndef AXI_ARB_ICACHE_PRIO_EN
        rrPtr_d = arHs ? ~grant : rrPtr_q;
`endif
    end

    assign idle = (state_q == ST_IDLE) && (cnt_q[0] == '0) && (cnt_q[1] == '0);

endmodule
